// File: rtl/tp_pkg.sv
// Shared types and default sizing for the test-point probe bank.
// Pure declarations: no latency, no flow control.
package tp_pkg;

    typedef enum logic {
        TP_RUN   = 1'b0,
        TP_BLANK = 1'b1
    } tp_state_e;

    localparam int TP_WIDTH_DEF     = 16;
    localparam int TP_NGRP_DEF      = 4;
    localparam int TP_STRETCH_DEF   = 8;
    localparam int TP_BLANK_CYC_DEF = 4;
    localparam int TP_HOLDOFF_DEF   = 1024;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tp_stretch.sv
// One-bit pulse stretcher: a rising edge on din holds dout high for STRETCH more cycles.
// Latency: combinational din -> dout; no backpressure, clr zeroes the counter.
module tp_stretch
    import tp_pkg::*;
#(
    parameter int STRETCH = TP_STRETCH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int CW = clog2_min1(STRETCH + 1);

    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_d = din;
        cnt_d  = cnt_q;
        if (clr || !ena) begin
            cnt_d = '0;
        end else if (din && !prev_q) begin
            // Retrigger: a fresh edge always reloads the full length.
            cnt_d = CW'(STRETCH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        dout = din | (ena && (cnt_q != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/tp_probe_bank.sv
// Test-point driver: muxes one of NGRP probe groups to TP pins with stretch, blanking and optional trigger (TP_TRIG_EN).
// Latency: PROBE -> TP_OUT 2 CLK; SCOPE_SYNC aligned with TP_OUT; select/dir writes take effect next CLK.
// Backpressure: none, outputs free-run every cycle; TP_OUT forced to zero while blanking.
module tp_probe_bank
    import tp_pkg::*;
#(
    parameter int               WIDTH     = TP_WIDTH_DEF,
    parameter int               NGRP      = TP_NGRP_DEF,
    parameter int               STRETCH   = TP_STRETCH_DEF,
    parameter int               BLANK_CYC = TP_BLANK_CYC_DEF,
    parameter int               HOLDOFF   = TP_HOLDOFF_DEF,
    parameter logic [WIDTH-1:0] DIR_RST   = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NGRP*WIDTH-1:0]        PROBE,
    input  logic                         SEL_WE,
    input  logic [clog2_min1(NGRP)-1:0]  SEL_DATA,
    input  logic                         DIR_WE,
    input  logic [WIDTH-1:0]             DIR_DATA,
    input  logic [WIDTH-1:0]             STRETCH_ENA,
    input  logic [WIDTH-1:0]             TRIG_MASK,
    input  logic [WIDTH-1:0]             TRIG_VAL,
    output logic [WIDTH-1:0]             TP_OUT,
    output logic [WIDTH-1:0]             TP_DIR,
    output logic [clog2_min1(NGRP)-1:0]  SEL_CUR,
    output logic                         BLANKING,
    output logic                         SCOPE_SYNC
);

    localparam int SW = clog2_min1(NGRP);
    localparam int BW = clog2_min1(BLANK_CYC + 1);

    tp_state_e        state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] grp, stretched;
    logic             sel_ok, stretch_clr;

    always_comb begin
        grp = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (sel_q == SW'(g)) grp = PROBE[g*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        sel_ok  = SEL_WE && (int'(SEL_DATA) < NGRP) && (SEL_DATA != sel_q);
        state_d = state_q;
        sel_d   = sel_q;
        blank_d = blank_q;
        if (sel_ok) begin
            // Also restarts the blank window when already blanking.
            sel_d   = SEL_DATA;
            state_d = TP_BLANK;
            blank_d = BW'(BLANK_CYC);
        end else if (state_q == TP_BLANK) begin
            if (blank_q <= BW'(1)) begin
                state_d = TP_RUN;
                blank_d = '0;
            end else begin
                blank_d = blank_q - BW'(1);
            end
        end
        dir_d       = DIR_WE ? DIR_DATA : dir_q;
        stage1_d    = grp;
        stretch_clr = (state_d == TP_BLANK);
        out_d       = (state_d == TP_BLANK) ? '0 : stretched;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_str
        tp_stretch #(.STRETCH(STRETCH)) u_str (
            .clk  (CLK),
            .rst  (RST),
            .ena  (STRETCH_ENA[i]),
            .clr  (stretch_clr),
            .din  (stage1_q[i]),
            .dout (stretched[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= TP_RUN;
            sel_q    <= '0;
            blank_q  <= '0;
            dir_q    <= DIR_RST;
            stage1_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            blank_q  <= blank_d;
            dir_q    <= dir_d;
            stage1_q <= stage1_d;
            out_q    <= out_d;
        end
    end

    assign TP_OUT   = out_q;
    assign TP_DIR   = dir_q;
    assign SEL_CUR  = sel_q;
    assign BLANKING = (state_q == TP_BLANK);

`ifdef TP_TRIG_EN
    localparam int HW = clog2_min1(HOLDOFF + 1);

    logic          match;
    logic          hist_q, hist_d;
    logic          sync_q, sync_d;
    logic [HW-1:0] hold_q, hold_d;

    // Evaluated on stage 1 and registered, so the pulse lines up with TP_OUT.
    always_comb begin
        match  = (((stage1_q ^ TRIG_VAL) & TRIG_MASK) == '0) && (TRIG_MASK != '0);
        sync_d = match && !hist_q && (state_d == TP_RUN) && (hold_q == '0);
        hist_d = (state_d == TP_BLANK) ? 1'b0 : match;
        hold_d = hold_q;
        if (sync_d) begin
            hold_d = HW'(HOLDOFF);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= 1'b0;
            sync_q <= 1'b0;
            hold_q <= '0;
        end else begin
            hist_q <= hist_d;
            sync_q <= sync_d;
            hold_q <= hold_d;
        end
    end

    assign SCOPE_SYNC = sync_q;
`else
    logic unused_trig;
    assign unused_trig = ^{TRIG_MASK, TRIG_VAL, 32'(HOLDOFF)};
    assign SCOPE_SYNC  = 1'b0;
`endif

endmodule

// File: tb/tb_tp_probe_bank.sv
// Bench for tp_probe_bank: directed stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
// A second NGRP=3 instance covers out-of-range select writes.
module tb_tp_probe_bank;

    localparam logic [15:0] DIR_RST_V = 16'h00F0;
`ifdef TP_TRIG_EN
    localparam logic SY = 1'b1;
`else
    localparam logic SY = 1'b0;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [6:0]  en;    // 0 out, 1 dir, 2 sel, 3 blank, 4 sync, 5 sel3, 6 blank3
        logic [15:0] out;
        logic [15:0] dir;
        logic [1:0]  sel;
        logic        blank;
        logic        sync;
        logic [1:0]  sel3;
        logic        blank3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] probe;
    logic        sel_we, dir_we, sel_we3;
    logic [1:0]  sel_data, sel_data3;
    logic [15:0] dir_data, stretch_ena, trig_mask, trig_val;
    logic [15:0] tp_out, tp_dir, tp_out3, tp_dir3;
    logic [1:0]  sel_cur, sel_cur3;
    logic        blanking, scope_sync, blanking3, scope_sync3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    tp_probe_bank #(.WIDTH(16), .NGRP(4), .DIR_RST(DIR_RST_V)) dut (
        .CLK(clk), .RST(rst), .PROBE(probe), .SEL_WE(sel_we), .SEL_DATA(sel_data),
        .DIR_WE(dir_we), .DIR_DATA(dir_data), .STRETCH_ENA(stretch_ena),
        .TRIG_MASK(trig_mask), .TRIG_VAL(trig_val), .TP_OUT(tp_out), .TP_DIR(tp_dir),
        .SEL_CUR(sel_cur), .BLANKING(blanking), .SCOPE_SYNC(scope_sync)
    );

    tp_probe_bank #(.WIDTH(16), .NGRP(3), .DIR_RST(DIR_RST_V)) dut3 (
        .CLK(clk), .RST(rst), .PROBE(probe[47:0]), .SEL_WE(sel_we3), .SEL_DATA(sel_data3),
        .DIR_WE(dir_we), .DIR_DATA(dir_data), .STRETCH_ENA(stretch_ena),
        .TRIG_MASK(trig_mask), .TRIG_VAL(trig_val), .TP_OUT(tp_out3), .TP_DIR(tp_dir3),
        .SEL_CUR(sel_cur3), .BLANKING(blanking3), .SCOPE_SYNC(scope_sync3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, string n, logic [6:0] en, logic [15:0] o, logic [15:0] d,
                                 logic [1:0] s, logic b, logic y, logic [1:0] s3, logic b3);
        exp_t e;
        e.cyc = c; e.name = n; e.en = en; e.out = o; e.dir = d; e.sel = s;
        e.blank = b; e.sync = y; e.sel3 = s3; e.blank3 = b3;
        sb.push_back(e);
    endfunction

    function automatic void exp_out(int c, string n, logic [15:0] o);
        push(c, n, 7'b0000001, o, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endfunction
    function automatic void exp_blank(int c, string n, logic b, logic [15:0] o);
        push(c, n, 7'b0001001, o, '0, '0, b, 1'b0, '0, 1'b0);
    endfunction
    function automatic void exp_sel(int c, string n, logic [1:0] s);
        push(c, n, 7'b0000100, '0, '0, s, 1'b0, 1'b0, '0, 1'b0);
    endfunction
    function automatic void exp_dir(int c, string n, logic [15:0] d);
        push(c, n, 7'b0000010, '0, d, '0, 1'b0, 1'b0, '0, 1'b0);
    endfunction
    function automatic void exp_sync(int c, string n, logic y, logic [15:0] o);
        push(c, n, 7'b0010001, o, '0, '0, 1'b0, y, '0, 1'b0);
    endfunction
    function automatic void exp_d3(int c, string n, logic [1:0] s3, logic b3);
        push(c, n, 7'b1100000, '0, '0, '0, 1'b0, 1'b0, s3, b3);
    endfunction
    function automatic void exp_rst(int c, string n);
        push(c, n, 7'b1111111, '0, DIR_RST_V, '0, 1'b0, 1'b0, '0, 1'b0);
    endfunction

    task automatic chk(string n, string f, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %h, expected %h (cycle %0d)", n, f, act, exp, cyc);
    endtask

    task automatic check_entry(exp_t e);
        if (e.en[0]) chk(e.name, "tp_out", tp_out, e.out);
        if (e.en[1]) chk(e.name, "tp_dir", tp_dir, e.dir);
        if (e.en[2]) chk(e.name, "sel_cur", {14'd0, sel_cur}, {14'd0, e.sel});
        if (e.en[3]) chk(e.name, "blanking", {15'd0, blanking}, {15'd0, e.blank});
        if (e.en[4]) chk(e.name, "scope_sync", {15'd0, scope_sync}, {15'd0, e.sync});
        if (e.en[5]) chk(e.name, "sel_cur3", {14'd0, sel_cur3}, {14'd0, e.sel3});
        if (e.en[6]) chk(e.name, "blanking3", {15'd0, blanking3}, {15'd0, e.blank3});
    endtask

    task automatic scan();
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc < cyc) begin
                n_checks++;
                $display("FAIL %s late: expected at cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                check_entry(sb[i]);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    always @(negedge clk) scan();

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c;
        rst = 1'b1; probe = '0; sel_we = 1'b0; sel_data = '0; sel_we3 = 1'b0; sel_data3 = '0;
        dir_we = 1'b0; dir_data = '0; stretch_ena = '0; trig_mask = '0; trig_val = '0;
        tick(2);
        exp_rst(cyc, "reset");
        tick(1);
        rst = 1'b0;

        // Two-cycle latency from PROBE to TP_OUT.
        c = cyc;
        probe = {16'hBEEF, 16'h1234, 16'h5A5A, 16'hA5A5};
        exp_out(c + 1, "lat_first", 16'h0000);
        exp_out(c + 2, "lat_grp0", 16'hA5A5);
        exp_dir(c + 1, "dir_rst", DIR_RST_V);
        tick(3);

        // Select group 2 with a simultaneous direction write.
        c = cyc;
        sel_we = 1'b1; sel_data = 2'd2; dir_we = 1'b1; dir_data = 16'hFF00;
        exp_blank(c, "pre_sel", 1'b0, 16'hA5A5);
        exp_dir(c + 1, "dir_we", 16'hFF00);
        exp_sel(c + 1, "sel2", 2'd2);
        for (int k = 1; k <= 4; k++) exp_blank(c + k, "blank4", 1'b1, 16'h0000);
        exp_blank(c + 5, "after_blank4", 1'b0, 16'h1234);
        tick(1);
        sel_we = 1'b0; dir_we = 1'b0;
        tick(6);

        // Reselect during BLANK restarts the window.
        c = cyc;
        sel_we = 1'b1; sel_data = 2'd1;
        exp_sel(c + 2, "sel1", 2'd1);
        exp_sel(c + 3, "sel3", 2'd3);
        for (int k = 1; k <= 6; k++) exp_blank(c + k, "blank6", 1'b1, 16'h0000);
        exp_blank(c + 7, "after_blank6", 1'b0, 16'hBEEF);
        tick(1);
        sel_we = 1'b0;
        tick(1);
        sel_we = 1'b1; sel_data = 2'd3;
        tick(1);
        sel_we = 1'b0;
        tick(5);

        // Write of the current group and out-of-range group are ignored.
        c = cyc;
        sel_we = 1'b1; sel_data = 2'd3; sel_we3 = 1'b1; sel_data3 = 2'd3;
        exp_blank(c + 1, "same_sel", 1'b0, 16'hBEEF);
        exp_blank(c + 2, "same_sel2", 1'b0, 16'hBEEF);
        exp_d3(c + 1, "oob_sel", 2'd0, 1'b0);
        exp_d3(c + 2, "oob_sel2", 2'd0, 1'b0);
        tick(1);
        sel_we = 1'b0; sel_we3 = 1'b0;
        tick(2);
        c = cyc;
        sel_we3 = 1'b1; sel_data3 = 2'd2;
        exp_d3(c + 1, "ngrp3_sel2", 2'd2, 1'b1);
        tick(1);
        sel_we3 = 1'b0;
        tick(6);

        // Stretch: bit0 enabled, bit1 not.
        probe[63:48] = 16'h1230; stretch_ena = 16'h0001;
        tick(3);
        c = cyc;
        probe[63:48] = 16'h1233;
        exp_out(c + 1, "str_pre", 16'h1230);
        exp_out(c + 2, "str_edge", 16'h1233);
        for (int k = 3; k <= 10; k++) exp_out(c + k, "str_hold", 16'h1231);
        exp_out(c + 11, "str_end", 16'h1230);
        exp_out(c + 12, "str_end2", 16'h1230);
        tick(1);
        probe[63:48] = 16'h1230;
        tick(15);

        // Retrigger three cycles after the first pulse.
        c = cyc;
        probe[63:48] = 16'h1231;
        exp_out(c + 1, "retrig_pre", 16'h1230);
        for (int k = 2; k <= 13; k++) exp_out(c + k, "retrig_hold", 16'h1231);
        exp_out(c + 14, "retrig_end", 16'h1230);
        exp_out(c + 15, "retrig_end2", 16'h1230);
        tick(1);
        probe[63:48] = 16'h1230;
        tick(2);
        probe[63:48] = 16'h1231;
        tick(1);
        probe[63:48] = 16'h1230;
        tick(14);

        // Trigger with holdoff.
        stretch_ena = '0; trig_mask = 16'h00FF; trig_val = 16'h0042;
        tick(2);
        c = cyc;
        probe[63:48] = 16'h7742;
        exp_sync(c + 1, "trig_pre", 1'b0, 16'h1230);
        exp_sync(c + 2, "trig_first", SY, 16'h7742);
        exp_sync(c + 3, "trig_once", 1'b0, 16'h7742);
        exp_sync(c + 4, "trig_gone", 1'b0, 16'h1230);
        exp_sync(c + 102, "trig_holdoff", 1'b0, 16'h7742);
        exp_sync(c + 1102, "trig_rearm", SY, 16'h7742);
        exp_sync(c + 1103, "trig_rearm_once", 1'b0, 16'h7742);
        tick(2);
        probe[63:48] = 16'h1230;
        tick(98);
        probe[63:48] = 16'h7742;
        tick(2);
        probe[63:48] = 16'h1230;
        tick(998);
        probe[63:48] = 16'h7742;
        tick(2);
        probe[63:48] = 16'h1230;
        tick(4);

        // Async reset mid-stretch, no residual pulse afterwards.
        trig_mask = '0; stretch_ena = 16'h0001;
        tick(2);
        c = cyc;
        probe[63:48] = 16'h1231; probe[15:0] = 16'h0000;
        exp_out(c + 2, "rst_str_pre", 16'h1231);
        exp_out(c + 3, "rst_str_pre2", 16'h1231);
        tick(1);
        probe[63:48] = 16'h1230;
        tick(3);
        rst = 1'b1;
        exp_rst(c + 4, "rst_mid_stretch");
        exp_rst(c + 5, "rst_hold");
        for (int k = 6; k <= 8; k++) exp_out(c + k, "no_residual", 16'h0000);
        exp_sel(c + 6, "rst_sel0", 2'd0);
        tick(1);
        rst = 1'b0;
        tick(4);

        // Async reset mid-BLANK.
        c = cyc;
        sel_we = 1'b1; sel_data = 2'd2;
        exp_blank(c + 1, "rst_blank_pre", 1'b1, 16'h0000);
        exp_sel(c + 1, "rst_blank_sel", 2'd2);
        exp_rst(c + 2, "rst_mid_blank");
        exp_blank(c + 4, "rst_blank_post", 1'b0, 16'h0000);
        exp_sel(c + 4, "rst_blank_sel0", 2'd0);
        tick(1);
        sel_we = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);

        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s never checked: expected at cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
